// File: rtl/fifo_rd_stream.sv
// Read-side FIFO consumer: pops words and re-presents them as a registered valid/ready stream.
// Optional delivered-word counter on o_wordCnt is enabled by defining FIFO_RD_STATS_EN.
module fifo_rd_stream #(
    parameter int DATA_W = 8
`ifdef FIFO_RD_STATS_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic              i_clk,
    input  logic              i_arst_n,
    input  logic              i_rEmpty,
    input  logic [DATA_W-1:0] i_rData,
    output logic              o_rInc,
    input  logic              i_flush,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_ready
`ifdef FIFO_RD_STATS_EN
    , output logic [CNT_W-1:0] o_wordCnt
`endif
);

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    logic [1:0]        count_q, count_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              take, give;

    // Pop never waits on i_ready; the skid entry absorbs the one-cycle ready lag.
    // Gating with the reset keeps the FIFO head untouched while we are held in reset.
    assign take    = !i_rEmpty && (count_q != OCC_TWO) && !i_flush && i_arst_n;
    assign o_valid = (count_q != OCC_EMPTY);
    assign give    = o_valid && i_ready;
    assign o_rInc  = take;
    assign o_data  = head_q;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (i_flush) begin
            count_d = OCC_EMPTY;
        end else begin
            case (count_q)
                OCC_EMPTY: begin
                    if (take) begin
                        count_d = OCC_ONE;
                        head_d  = i_rData;
                    end
                end
                OCC_ONE: begin
                    if (take && give) begin
                        head_d = i_rData;
                    end else if (take) begin
                        count_d = OCC_TWO;
                        skid_d  = i_rData;
                    end else if (give) begin
                        count_d = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    if (give) begin
                        count_d = OCC_ONE;
                        head_d  = skid_q;
                    end
                end
                default: count_d = OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            count_q <= OCC_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

`ifdef FIFO_RD_STATS_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A word presented in a flush cycle is dropped, not delivered.
    assign cnt_d     = (give && !i_flush) ? cnt_q + 1'b1 : cnt_q;
    assign o_wordCnt = cnt_q;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) cnt_q <= '0;
        else           cnt_q <= cnt_d;
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: behavioural FIFO model feeding the DUT, scoreboard monitor on the stream.
module tb_fifo_rd_stream;
    logic       i_clk = 1'b0;
    logic       i_arst_n = 1'b0;
    logic       i_rEmpty;
    logic [7:0] i_rData;
    logic       o_rInc;
    logic       i_flush = 1'b0;
    logic       o_valid;
    logic [7:0] o_data;
    logic       i_ready = 1'b0;
`ifdef FIFO_RD_STATS_EN
    logic [3:0] o_wordCnt;
`endif

    int tests = 0;
    int failed = 0;

    logic [7:0] mem [0:63];
    int         wp = 0;
    int         rp = 0;
    logic       gate_e = 1'b0;
    logic [7:0] exp_q [$];

    always #5 i_clk = ~i_clk;

    assign i_rEmpty = (rp == wp) || gate_e;
    assign i_rData  = mem[rp];

    always @(posedge i_clk) if (o_rInc) rp <= rp + 1;

`ifdef FIFO_RD_STATS_EN
    fifo_rd_stream #(.DATA_W(8), .CNT_W(4)) dut (
        .i_clk(i_clk), .i_arst_n(i_arst_n), .i_rEmpty(i_rEmpty), .i_rData(i_rData),
        .o_rInc(o_rInc), .i_flush(i_flush), .o_valid(o_valid), .o_data(o_data),
        .i_ready(i_ready), .o_wordCnt(o_wordCnt));
`else
    fifo_rd_stream #(.DATA_W(8)) dut (
        .i_clk(i_clk), .i_arst_n(i_arst_n), .i_rEmpty(i_rEmpty), .i_rData(i_rData),
        .o_rInc(o_rInc), .i_flush(i_flush), .o_valid(o_valid), .o_data(o_data),
        .i_ready(i_ready));
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stream monitor: every accepted word must be the next expected one.
    always @(negedge i_clk) begin
        if (i_arst_n && o_valid && i_ready && !i_flush) begin
            if (exp_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL stream_extra: got %0h expected none", o_data);
            end else begin
                check("stream_data", {24'd0, o_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wp] = b;
        wp++;
        exp_q.push_back(b);
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() > 0; i++) step();
        step();
        check(name, exp_q.size(), 0);
    endtask

    int r0;

    initial begin
        // Reset with three words preloaded
        i_ready = 1'b1;
        push(8'h11); push(8'h22); push(8'h33);
        #2;
        check("rst_valid", o_valid, 0);
        check("rst_data", o_data, 0);
        check("rst_rinc", o_rInc, 0);
        step();
        check("rst_rinc_hold", o_rInc, 0);
        i_arst_n = 1'b1;
        #1;
        check("t1_rinc0", o_rInc, 1);
        step();
        check("t1_v1", o_valid, 1); check("t1_d1", o_data, 8'h11); check("t1_rinc1", o_rInc, 1);
        step();
        check("t1_v2", o_valid, 1); check("t1_d2", o_data, 8'h22); check("t1_rinc2", o_rInc, 1);
        step();
        check("t1_v3", o_valid, 1); check("t1_d3", o_data, 8'h33); check("t1_rinc3", o_rInc, 0);
        step();
        check("t1_vdrop", o_valid, 0);

        // Backpressure: only two pops, head held
        i_ready = 1'b0;
        r0 = rp;
        push(8'h41); push(8'h42); push(8'h43); push(8'h44);
        repeat (5) step();
        check("t2_pops", rp - r0, 2);
        check("t2_valid", o_valid, 1);
        check("t2_hold", o_data, 8'h41);
        check("t2_rinc", o_rInc, 0);
        i_ready = 1'b1;
        drain("t2_drain", 20);
        check("t2_pops_all", rp - r0, 4);

        // Empty flag toggling every cycle
        gate_e = 1'b1;
        push(8'h51); push(8'h52); push(8'h53); push(8'h54); push(8'h55);
        for (int i = 0; i < 30 && exp_q.size() > 0; i++) begin
            gate_e = ~gate_e;
            step();
        end
        gate_e = 1'b0;
        step();
        check("t3_drain", exp_q.size(), 0);
        check("t3_fifo_empty", wp - rp, 0);
        check("t3_vdrop", o_valid, 0);

        // Flush with both entries occupied
        i_ready = 1'b0;
        push(8'h61); push(8'h62); push(8'h63);
        step(); step();
        check("t4_full_rinc", o_rInc, 0);
        check("t4_full_valid", o_valid, 1);
        i_flush = 1'b1;
        #1 check("t4_flush_rinc", o_rInc, 0);
        void'(exp_q.pop_front()); void'(exp_q.pop_front());
        step();
        i_flush = 1'b0;
        check("t4_valid_after", o_valid, 0);
        check("t4_fifo_kept", wp - rp, 1);
        i_ready = 1'b1;
        drain("t4_drain", 10);
        // Flush while empty with a word waiting: nothing may be popped
        push(8'h64);
        i_flush = 1'b1;
        #1 check("t4_flush_rinc_e", o_rInc, 0);
        step();
        i_flush = 1'b0;
        check("t4_fifo_kept2", wp - rp, 1);
        drain("t4_drain2", 10);

        // Asynchronous reset while two entries are held
        i_ready = 1'b0;
        push(8'h71); push(8'h72); push(8'h73);
        step(); step();
        check("t5_valid_pre", o_valid, 1);
        #2 i_arst_n = 1'b0;
        #1;
        check("t5_valid", o_valid, 0);
        check("t5_data", o_data, 0);
        void'(exp_q.pop_front()); void'(exp_q.pop_front());
        step();
        i_arst_n = 1'b1;
        i_ready = 1'b1;
        drain("t5_drain", 10);
        check("t5_d73_gone", o_valid, 0);

`ifdef FIFO_RD_STATS_EN
        // Delivered-word counter wraps at 16 and ignores flush
        #2 i_arst_n = 1'b0;
        step();
        i_arst_n = 1'b1;
        check("t6_cnt_rst", o_wordCnt, 0);
        for (int i = 0; i < 17; i++) push(8'h80 + 8'(i));
        drain("t6_drain", 40);
        check("t6_cnt_wrap", o_wordCnt, 1);
        push(8'h9a);
        step();
        check("t6_valid", o_valid, 1);
        i_flush = 1'b1;
        void'(exp_q.pop_front());
        step();
        i_flush = 1'b0;
        check("t6_cnt_flush", o_wordCnt, 1);
        check("t6_valid_after", o_valid, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
